// File: rtl/ccip_mmio_csr.sv
// ccip_mmio_csr: MMIO CSR responder on CCI-P c0 Rx (requests) and c2 Tx
// (read responses). It holds eight 64-bit CSRs and answers every read with
// a fixed two-cycle latency.
//
// Flattened bus layouts (packed, MSB first):
//   c0 Rx (543): hdr[542:515] | data[514:3] | rspValid[2] | mmioRdValid[1] | mmioWrValid[0]
//     MMIO hdr : address[542:527] | length[526:525] | rsvd[524] | tid[523:515]
//   c2 Tx (74) : tid[73:65] | mmioRdValid[64] | data[63:0]
module ccip_mmio_csr #(
  parameter logic [15:0] MMIO_BASE = 16'h0000,
  parameter logic [63:0] AFU_DFH   = 64'h1000_0000_0000_1001,
  parameter logic [63:0] AFU_ID_L  = 64'h0,
  parameter logic [63:0] AFU_ID_H  = 64'h0
) (
  input  logic         pClk,
  input  logic         pck_cp2af_softReset,
  input  logic [542:0] pck_cp2af_sRx_c0,
  output logic [73:0]  pck_af2cp_sTx_c2,
  input  logic [63:0]  status_in,
  output logic [63:0]  ctrl_reg,
  output logic         ctrl_start,
  output logic         err_sticky
);

  localparam int NUM_CSR  = 8;
  localparam int IDX_DFH  = 0;
  localparam int IDX_IDL  = 1;
  localparam int IDX_IDH  = 2;
  localparam int IDX_SCR  = 3;
  localparam int IDX_CTRL = 4;
  localparam int IDX_STAT = 5;
  localparam int IDX_CYC  = 6;
  localparam int IDX_WRC  = 7;

  logic srst;
  assign srst = pck_cp2af_softReset;

  // ---------------------------------------------------------------------
  // Request field extraction
  // ---------------------------------------------------------------------
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic [8:0]  req_tid;
  logic [63:0] req_data;
  logic        rd_valid;
  logic        wr_valid;

  assign req_addr = pck_cp2af_sRx_c0[542:527];
  assign req_len  = pck_cp2af_sRx_c0[526:525];
  assign req_tid  = pck_cp2af_sRx_c0[523:515];
  assign req_data = pck_cp2af_sRx_c0[66:3];
  assign rd_valid = pck_cp2af_sRx_c0[1];
  assign wr_valid = pck_cp2af_sRx_c0[0];

  // rspValid, the reserved header bit and the upper data lanes are not used.
  logic unused_rx_bits;
  assign unused_rx_bits = ^{pck_cp2af_sRx_c0[524], pck_cp2af_sRx_c0[514:67],
                            pck_cp2af_sRx_c0[2]};

  // ---------------------------------------------------------------------
  // Address / length decode
  // ---------------------------------------------------------------------
  logic       req_hit;
  logic [2:0] req_idx;
  logic       req_upper;
  logic       req_full;
  logic       req_legal;
  logic       wr_fire;
  logic       wr_bad;
  logic       rd_bad;

  assign req_hit   = (req_addr[15:4] == MMIO_BASE[15:4]);
  assign req_idx   = req_addr[3:1];
  assign req_upper = req_addr[0];
  assign req_full  = (req_len == 2'b01);
  // 4B is always legal; 8B needs an even DW address; 2'b10/2'b11 never legal.
  assign req_legal = (req_len == 2'b00) || (req_full && !req_addr[0]);

  // Only accesses inside our window can be illegal; foreign traffic is
  // simply not ours to judge.
  assign wr_fire = wr_valid && req_hit && req_legal;
  assign wr_bad  = wr_valid && req_hit && !req_legal;
  assign rd_bad  = rd_valid && req_hit && !req_legal;

  // One write strobe per CSR slot.
  logic [NUM_CSR-1:0] wr_sel;
  generate
    for (genvar gi = 0; gi < NUM_CSR; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_fire && (req_idx == 3'(gi));
    end
  endgenerate

  // Merge write data into an existing CSR value: full 64 bits for 8B,
  // otherwise only the addressed DW takes data[31:0].
  function automatic logic [63:0] merge_dw(input logic [63:0] old_val,
                                           input logic [63:0] wdata,
                                           input logic        full,
                                           input logic        upper);
    logic [63:0] res;
    if (full) begin
      res = wdata;
    end else if (upper) begin
      res = {wdata[31:0], old_val[31:0]};
    end else begin
      res = {old_val[63:32], wdata[31:0]};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Writable state
  // ---------------------------------------------------------------------
  logic [63:0] scratch_reg;
  logic [63:0] scratch_next;
  logic [63:0] ctrl_next;
  logic        ctrl_start_reg;
  logic        ctrl_start_next;
  logic [63:0] cycles_reg;
  logic [63:0] cycles_next;
  logic [31:0] wrcnt_reg;
  logic [31:0] wrcnt_next;
  logic        err_reg;
  logic        err_next;

  // Next-state for the CSR bank and side-band outputs.
  always_comb begin
    scratch_next    = scratch_reg;
    ctrl_next       = ctrl_reg;
    ctrl_start_next = 1'b0;
    cycles_next     = cycles_reg + 64'd1;
    wrcnt_next      = wrcnt_reg;
    err_next        = err_reg;

    if (wr_sel[IDX_SCR]) begin
      scratch_next = merge_dw(scratch_reg, req_data, req_full, req_upper);
    end

    if (wr_sel[IDX_CTRL]) begin
      // Bit 0 is a command bit: it fires ctrl_start and never sticks.
      ctrl_next       = merge_dw(ctrl_reg, req_data, req_full, req_upper);
      ctrl_next[0]    = 1'b0;
      ctrl_start_next = req_data[0];
    end

    // Any accepted write to CYCLES restarts it from zero.
    if (wr_sel[IDX_CYC]) begin
      cycles_next = 64'd0;
    end

    // Every accepted in-window write counts, RO targets included.
    if (wr_fire && (wrcnt_reg != 32'hFFFF_FFFF)) begin
      wrcnt_next = wrcnt_reg + 32'd1;
    end

    if (wr_bad || rd_bad) begin
      err_next = 1'b1;
    end
  end

  // CSR bank and side-band state registers.
  always_ff @(posedge pClk) begin
    if (srst) begin
      scratch_reg    <= 64'd0;
      ctrl_reg       <= 64'd0;
      ctrl_start_reg <= 1'b0;
      cycles_reg     <= 64'd0;
      wrcnt_reg      <= 32'd0;
      err_reg        <= 1'b0;
    end else begin
      scratch_reg    <= scratch_next;
      ctrl_reg       <= ctrl_next;
      ctrl_start_reg <= ctrl_start_next;
      cycles_reg     <= cycles_next;
      wrcnt_reg      <= wrcnt_next;
      err_reg        <= err_next;
    end
  end

  assign ctrl_start = ctrl_start_reg;
  assign err_sticky = err_reg;

  // ---------------------------------------------------------------------
  // Read pipeline, stage 1: capture the request and its decode.
  // The CYCLES snapshot takes cycles_next so the value returned is the one
  // the counter holds in the cycle after the request.
  // ---------------------------------------------------------------------
  logic        s1_valid_reg;
  logic [8:0]  s1_tid_reg;
  logic [2:0]  s1_idx_reg;
  logic        s1_upper_reg;
  logic        s1_full_reg;
  logic        s1_ok_reg;
  logic [63:0] s1_cycles_reg;

  // Stage-1 request capture.
  always_ff @(posedge pClk) begin
    if (srst) begin
      s1_valid_reg  <= 1'b0;
      s1_tid_reg    <= 9'd0;
      s1_idx_reg    <= 3'd0;
      s1_upper_reg  <= 1'b0;
      s1_full_reg   <= 1'b0;
      s1_ok_reg     <= 1'b0;
      s1_cycles_reg <= 64'd0;
    end else begin
      s1_valid_reg <= rd_valid;
      if (rd_valid) begin
        s1_tid_reg    <= req_tid;
        s1_idx_reg    <= req_idx;
        s1_upper_reg  <= req_upper;
        s1_full_reg   <= req_full;
        s1_ok_reg     <= req_hit && req_legal;
        s1_cycles_reg <= cycles_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline, stage 2: select the CSR and shape it for the length.
  // ---------------------------------------------------------------------
  logic [63:0] csr_value;
  logic [31:0] csr_dw;
  logic [63:0] rd_data_next;

  // CSR read mux and response shaping.
  always_comb begin
    csr_value = 64'd0;
    unique case (s1_idx_reg)
      3'(IDX_DFH):  csr_value = AFU_DFH;
      3'(IDX_IDL):  csr_value = AFU_ID_L;
      3'(IDX_IDH):  csr_value = AFU_ID_H;
      3'(IDX_SCR):  csr_value = scratch_reg;
      3'(IDX_CTRL): csr_value = ctrl_reg;
      3'(IDX_STAT): csr_value = status_in;
      3'(IDX_CYC):  csr_value = s1_cycles_reg;
      3'(IDX_WRC):  csr_value = {32'd0, wrcnt_reg};
      default:      csr_value = 64'd0;
    endcase

    csr_dw = s1_upper_reg ? csr_value[63:32] : csr_value[31:0];

    if (!s1_ok_reg) begin
      rd_data_next = 64'd0;
    end else if (s1_full_reg) begin
      rd_data_next = csr_value;
    end else begin
      rd_data_next = {csr_dw, csr_dw};
    end
  end

  logic        c2_valid_reg;
  logic [8:0]  c2_tid_reg;
  logic [63:0] c2_data_reg;

  // Stage-2 c2 response register; hdr/data hold between responses.
  always_ff @(posedge pClk) begin
    if (srst) begin
      c2_valid_reg <= 1'b0;
      c2_tid_reg   <= 9'd0;
      c2_data_reg  <= 64'd0;
    end else begin
      c2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        c2_tid_reg  <= s1_tid_reg;
        c2_data_reg <= rd_data_next;
      end
    end
  end

  assign pck_af2cp_sTx_c2 = {c2_tid_reg, c2_valid_reg, c2_data_reg};

endmodule

// File: tb/tb_ccip_mmio_csr.sv
// Directed self-checking bench for ccip_mmio_csr.
module tb_ccip_mmio_csr;

  localparam logic [63:0] DFH    = 64'h1000_0000_0000_1001;
  localparam logic [63:0] STATUS = 64'h5A5A_0000_1234_ABCD;
  localparam logic [63:0] SCR    = 64'hCAFE_F00D_0123_4567;

  logic         clk;
  logic         srst;
  logic [542:0] rx;
  logic [73:0]  c2;
  logic [63:0]  status_in;
  logic [63:0]  ctrl_reg;
  logic         ctrl_start;
  logic         err_sticky;

  int total;
  int bad;

  ccip_mmio_csr dut (
    .pClk                (clk),
    .pck_cp2af_softReset (srst),
    .pck_cp2af_sRx_c0    (rx),
    .pck_af2cp_sTx_c2    (c2),
    .status_in           (status_in),
    .ctrl_reg            (ctrl_reg),
    .ctrl_start          (ctrl_start),
    .err_sticky          (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one write for one cycle; returns #1 into the following cycle.
  task automatic mmio_wr(input logic [15:0] addr, input logic [1:0] len,
                         input logic [63:0] data);
    rx = '0;
    rx[542:527] = addr;
    rx[526:525] = len;
    rx[66:3]    = data;
    rx[0]       = 1'b1;
    @(posedge clk); #1;
    rx = '0;
    $display("wr addr=%h len=%b data=%h", addr, len, data);
  endtask

  // Present one read; sample c2 valid in the three following cycles and
  // the response contents at T+2.
  task automatic mmio_rd(input logic [15:0] addr, input logic [1:0] len,
                         input logic [8:0] tid, output logic v1, output logic v2,
                         output logic v3, output logic [8:0] tid_o,
                         output logic [63:0] data_o);
    rx = '0;
    rx[542:527] = addr;
    rx[526:525] = len;
    rx[523:515] = tid;
    rx[1]       = 1'b1;
    @(posedge clk); #1;
    rx = '0;
    v1 = c2[64];
    @(posedge clk); #1;
    v2     = c2[64];
    tid_o  = c2[73:65];
    data_o = c2[63:0];
    @(posedge clk); #1;
    v3 = c2[64];
    $display("rd addr=%h len=%b tid=%h -> valid=%b tid=%h data=%h",
             addr, len, tid, v2, tid_o, data_o);
  endtask

  task automatic test_reset();
    logic v1, v2, v3;
    logic [8:0] t;
    logic [63:0] d;
    srst = 1'b1;
    rx = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (c2 !== 74'd0) begin bad++; $display("FAIL reset_c2 got=%h want=0", c2); end
    total++; if (ctrl_reg !== 64'd0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", ctrl_reg); end
    total++; if (ctrl_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", ctrl_start); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_sticky); end
    srst = 1'b0;
    @(posedge clk); #1;
    mmio_rd(16'h0000, 2'b01, 9'h1A5, v1, v2, v3, t, d);
    total++; if ({v1, v2, v3} !== 3'b010) begin bad++; $display("FAIL dfh_valid got=%b want=010", {v1, v2, v3}); end
    total++; if (t !== 9'h1A5) begin bad++; $display("FAIL dfh_tid got=%h want=1a5", t); end
    total++; if (d !== DFH) begin bad++; $display("FAIL dfh_data got=%h want=%h", d, DFH); end
    mmio_rd(16'h0006, 2'b01, 9'h001, v1, v2, v3, t, d);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL scratch_rst got=%h want=0", d); end
  endtask

  task automatic test_scratch();
    logic v1, v2, v3;
    logic [8:0] t;
    logic [63:0] d;
    mmio_wr(16'h0006, 2'b01, 64'hDEAD_BEEF_0123_4567);
    mmio_wr(16'h0007, 2'b00, 64'h0000_0000_CAFE_F00D);
    mmio_rd(16'h0006, 2'b01, 9'h010, v1, v2, v3, t, d);
    total++; if (d !== SCR) begin bad++; $display("FAIL scr_8b got=%h want=%h", d, SCR); end
    mmio_rd(16'h0006, 2'b00, 9'h011, v1, v2, v3, t, d);
    total++; if (d !== 64'h0123_4567_0123_4567) begin bad++; $display("FAIL scr_4b_lo got=%h want=0123456701234567", d); end
    mmio_rd(16'h0007, 2'b00, 9'h012, v1, v2, v3, t, d);
    total++; if (d !== 64'hCAFE_F00D_CAFE_F00D) begin bad++; $display("FAIL scr_4b_hi got=%h want=cafef00dcafef00d", d); end
    mmio_rd(16'h0001, 2'b00, 9'h013, v1, v2, v3, t, d);
    total++; if (d !== 64'h1000_0000_1000_0000) begin bad++; $display("FAIL dfh_4b_hi got=%h want=1000000010000000", d); end
  endtask

  task automatic test_ctrl_cycles();
    logic v1, v2, v3;
    logic [8:0] t;
    logic [63:0] d;
    mmio_wr(16'h0008, 2'b01, 64'h0000_0000_0000_0005);
    total++; if (ctrl_start !== 1'b1) begin bad++; $display("FAIL start_pulse got=%b want=1", ctrl_start); end
    total++; if (ctrl_reg !== 64'h4) begin bad++; $display("FAIL ctrl_val got=%h want=4", ctrl_reg); end
    @(posedge clk); #1;
    total++; if (ctrl_start !== 1'b0) begin bad++; $display("FAIL start_clear got=%b want=0", ctrl_start); end
    mmio_wr(16'h000C, 2'b01, 64'h1234);
    mmio_rd(16'h000C, 2'b01, 9'h020, v1, v2, v3, t, d);
    total++; if (d !== 64'h1) begin bad++; $display("FAIL cycles_clr got=%h want=1", d); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d [8];
    exp_d[0] = DFH;   exp_d[1] = 64'd0; exp_d[2] = 64'd0;  exp_d[3] = SCR;
    exp_d[4] = 64'h4; exp_d[5] = STATUS; exp_d[6] = 64'd7; exp_d[7] = 64'd5;
    // Clear CYCLES right before the burst so the CSR 6 read is predictable.
    mmio_wr(16'h000C, 2'b01, 64'd0);
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc >= 2 && cyc < 10) begin
        total++; if (c2[64] !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b want=1", cyc - 2, c2[64]); end
        total++; if (c2[73:65] !== 9'(cyc - 2)) begin bad++; $display("FAIL b2b_tid%0d got=%h want=%h", cyc - 2, c2[73:65], 9'(cyc - 2)); end
        total++; if (c2[63:0] !== exp_d[cyc - 2]) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", cyc - 2, c2[63:0], exp_d[cyc - 2]); end
        $display("b2b rsp tid=%h data=%h", c2[73:65], c2[63:0]);
      end else begin
        total++; if (c2[64] !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d got=%b want=0", cyc, c2[64]); end
      end
      rx = '0;
      if (cyc < 8) begin
        rx[542:527] = 16'(2 * cyc);
        rx[526:525] = 2'b01;
        rx[523:515] = 9'(cyc);
        rx[1]       = 1'b1;
      end
      @(posedge clk); #1;
    end
    rx = '0;
  endtask

  task automatic test_window();
    logic v1, v2, v3;
    logic [8:0] t;
    logic [63:0] d;
    mmio_wr(16'h0046, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    mmio_rd(16'h0006, 2'b01, 9'h030, v1, v2, v3, t, d);
    total++; if (d !== SCR) begin bad++; $display("FAIL oow_wr got=%h want=%h", d, SCR); end
    mmio_rd(16'h0106, 2'b01, 9'h0F3, v1, v2, v3, t, d);
    total++; if (v2 !== 1'b1 || t !== 9'h0F3) begin bad++; $display("FAIL oow_rsp got=%b/%h want=1/0f3", v2, t); end
    total++; if (d !== 64'd0) begin bad++; $display("FAIL oow_data got=%h want=0", d); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL oow_err got=%b want=0", err_sticky); end
    mmio_rd(16'h000E, 2'b01, 9'h031, v1, v2, v3, t, d);
    total++; if (d !== 64'd5) begin bad++; $display("FAIL oow_wrcnt got=%h want=5", d); end
  endtask

  task automatic test_illegal();
    logic v1, v2, v3;
    logic [8:0] t;
    logic [63:0] d;
    mmio_wr(16'h0007, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL ill_err got=%b want=1", err_sticky); end
    mmio_wr(16'h0006, 2'b11, 64'd0);
    mmio_rd(16'h0006, 2'b01, 9'h040, v1, v2, v3, t, d);
    total++; if (d !== SCR) begin bad++; $display("FAIL ill_scr got=%h want=%h", d, SCR); end
    mmio_rd(16'h000E, 2'b01, 9'h041, v1, v2, v3, t, d);
    total++; if (d !== 64'd5) begin bad++; $display("FAIL ill_wrcnt got=%h want=5", d); end
    mmio_rd(16'h0000, 2'b10, 9'h1FF, v1, v2, v3, t, d);
    total++; if ({v1, v2, v3} !== 3'b010 || t !== 9'h1FF) begin bad++; $display("FAIL ill_rd_rsp got=%b/%h want=010/1ff", {v1, v2, v3}, t); end
    total++; if (d !== 64'd0) begin bad++; $display("FAIL ill_rd_data got=%h want=0", d); end
  endtask

  task automatic test_reset_midflight();
    logic v1, v2, v3;
    logic [8:0] t;
    logic [63:0] d;
    rx = '0;
    rx[542:527] = 16'h0006;
    rx[526:525] = 2'b01;
    rx[523:515] = 9'h055;
    rx[1]       = 1'b1;
    @(posedge clk); #1;
    rx = '0;
    srst = 1'b1;
    @(posedge clk); #1;
    total++; if (c2 !== 74'd0) begin bad++; $display("FAIL mid_rst_c2 got=%h want=0", c2); end
    @(posedge clk); #1;
    srst = 1'b0;
    total++; if (err_sticky !== 1'b0 || ctrl_reg !== 64'd0) begin bad++; $display("FAIL mid_rst_side got=%b/%h want=0/0", err_sticky, ctrl_reg); end
    mmio_rd(16'h0006, 2'b01, 9'h060, v1, v2, v3, t, d);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL mid_rst_scr got=%h want=0", d); end
    mmio_rd(16'h0008, 2'b01, 9'h061, v1, v2, v3, t, d);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL mid_rst_ctrl got=%h want=0", d); end
    mmio_rd(16'h000E, 2'b01, 9'h062, v1, v2, v3, t, d);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL mid_rst_wrcnt got=%h want=0", d); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    status_in = STATUS;
    srst = 1'b1;
    rx = '0;
    test_reset();
    test_scratch();
    test_ctrl_cycles();
    test_back_to_back();
    test_window();
    test_illegal();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccip_mmio_csr.md
# ccip_mmio_csr

AFU-side MMIO CSR responder sitting directly on the CCI-P channel 0 receive path and the channel 2 transmit path. It decodes MMIO read and write requests carried on `t_if_ccip_c0_Rx`, overlaying the header as `t_ccip_c0_ReqMmioHdr`. It maintains a fixed bank of eight 64-bit CSRs and returns read data on `t_if_ccip_c2_Tx` with fixed latency, well inside `CCIP_MMIO_RD_TIMEOUT`.

## Interface
- MMIO_BASE, 16'h0000, DWORD address of CSR 0; must be 16-DW aligned (bits [3:0] = 0)
- AFU_DFH, 64'h1000_0000_0000_1001, read-only value of CSR 0
- AFU_ID_L, 64'h0, read-only value of CSR 1
- AFU_ID_H, 64'h0, read-only value of CSR 2

Ports:
- pClk  in  1  clock; single clock domain
- pck_cp2af_softReset  in  1  reset, synchronous, active-high
- pck_cp2af_sRx_c0  in  543  `t_if_ccip_c0_Rx`; only `mmioRdValid`, `mmioWrValid`, hdr and data[63:0] are used
- pck_af2cp_sTx_c2  out  74  `t_if_ccip_c2_Tx` MMIO read response
- status_in  in  64  live status, read through CSR 5
- ctrl_reg  out  64  CSR 4 contents; bit 0 always reads 0
- ctrl_start  out  1  one-cycle pulse on a CSR 4 write with data bit 0 = 1
- err_sticky  out  1  set by an illegal MMIO access; cleared only by reset

## Operation
- **Window hit:** `address[15:4] == MMIO_BASE[15:4]`.
  - CSR index = `address[3:1]`.
  - `address[0]` selects the upper DW for 4B accesses.
- **Lengths:**
  - 2'b00 = 4B.
  - 2'b01 = 8B; requires `address[0]` = 0.
  - 2'b10 and 2'b11 are illegal.
- **CSR map:**
  - 0: DFH (RO).
  - 1: ID_L (RO).
  - 2: ID_H (RO).
  - 3: SCRATCH (RW).
  - 4: CTRL (RW; bit 0 self-clears).
  - 5: STATUS (RO; `status_in`).
  - 6: CYCLES (64-bit free-running counter, +1 every cycle, wraps; any write clears it to 0).
  - 7: WRCNT (bits [31:0] count accepted writes in the window, saturate at 32'hFFFF_FFFF; upper bits read 0; RO).
- **Writes:**
  - 8B write updates all 64 bits.
  - 4B write updates only the addressed DW using data[31:0].
  - Writes to RO CSRs are accepted and ignored, but still counted in WRCNT.
- **Illegal accesses:** a write with length 2'b10/2'b11, or an 8B access with `address[0]` = 1:
  - write is dropped, not counted, sets `err_sticky`;
  - read still responds (see Read data).
- **Writes outside the window:** ignored, not counted, no error.
- **Read data:**
  - 8B read returns the CSR.
  - 4B read returns the addressed DW replicated in [63:32] and [31:0].
  - Out-of-window or illegal read returns 0; illegal read sets `err_sticky`.
  - Every read is answered; none is ever dropped.
- **Response header:** tid is returned unchanged from the request header.

## Timing
- **Read pipeline:** two registered stages.
  - Stage 1 latches tid, index, DW select, length and legality.
  - Stage 2 muxes the CSR value into the c2 register.
  - Request at cycle T gives `mmioRdValid` at T+2, high for exactly one cycle.
- Reads may arrive on consecutive cycles; full throughput, responses in request order.
- **Write visibility:** a write at T is visible from T+1. A read issued at T+1 returns the new value.
- **CYCLES snapshot:** a read issued at T returns the counter value held during T+1, i.e. stage-1 capture.
- **CYCLES clear:** a write at T makes CYCLES read 0 during T+1, then it increments from there.
- **ctrl_start:** a CSR 4 write at T pulses `ctrl_start` during T+1. `ctrl_reg` updates at T+1 with bit 0 forced to 0.
- Only one of `mmioRdValid` / `mmioWrValid` / `rspValid` is high per cycle. `rspValid` cycles are ignored.
- **Reset:**
  - `pck_af2cp_sTx_c2` is all zero.
  - `ctrl_start`, `ctrl_reg`, `err_sticky`, SCRATCH, CYCLES and WRCNT are all 0.
  - Reset mid-pipeline discards in-flight reads; no response is emitted for them.
- **While `mmioRdValid` is low:** c2 hdr and data hold their last values; the bench checks them only when valid.

## Test plan
- **Reset defaults:** reset, then 8B read of CSR 0 with tid 9'h1A5 → c2 valid at T+2, tid 9'h1A5, data = AFU_DFH. A CSR 3 read returns 0.
- **SCRATCH partial write:**
  - 8B write 64'hDEAD_BEEF_0123_4567 to CSR 3.
  - 4B write 32'hCAFE_F00D at DW address MMIO_BASE+7.
  - 8B read → 64'hCAFE_F00D_0123_4567.
  - 4B read at DW MMIO_BASE+6 → 64'h0123_4567_0123_4567.
- **Back-to-back reads:** reads of CSRs 0..7 on 8 consecutive cycles with tids 0..7 → 8 consecutive responses with matching tids and values. WRCNT equals the number of prior in-window writes.
- **CTRL and CYCLES:**
  - CTRL write 64'h0000_0000_0000_0005 → `ctrl_start` high for one cycle; `ctrl_reg` = 64'h4.
  - Write CSR 6 at T, read CSR 6 at T+1 → 64'h1.
- **Illegal and out-of-window accesses:**
  - 8B write at odd DW address → no CSR change, WRCNT unchanged, `err_sticky` = 1.
  - Read with length 2'b10 → response with data 0.
  - Out-of-window read → data 0, `err_sticky` unchanged by it.
- **Reset mid-flight:** a read is issued at T and reset is asserted at T+1 → no c2 valid at T+2. All CSRs return their reset values afterward.
